alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that sits in front of the 32-bit ALU. It accepts decoded instruction fields and register operands over a valid/ready handshake, and translates opcode/funct3/funct7 into the ALU's 4-bit operation code. It drives registered operands into the ALU, captures the ALU result and zero flag, and returns them over a second valid/ready handshake. This block is the initiator side of the ALU operation interface.

---
 rtl/alu_issue_ctrl_if.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 112 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-side signal bundle for the ALU issue controller.
// slave = controller view, master = requester/response-consumer/ALU view.
interface alu_issue_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic [6:0]            opcode_i;
  logic [2:0]            funct3_i;
  logic [6:0]            funct7_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [3:0]            ALU_Operation_o;
  logic [DATA_WIDTH-1:0] A_o;
  logic [DATA_WIDTH-1:0] B_o;
  logic [DATA_WIDTH-1:0] ALU_Result_i;
  logic                  Zero_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;
  logic                  illegal_o;

  modport slave (
    input  valid_i, opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i, imm_i,
    input  ALU_Result_i, Zero_i, resp_ready_i,
    output ready_o, ALU_Operation_o, A_o, B_o, resp_valid_o, result_o, zero_o, illegal_o
  );

  modport master (
    output valid_i, opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i, imm_i,
    output ALU_Result_i, Zero_i, resp_ready_i,
    input  ready_o, ALU_Operation_o, A_o, B_o, resp_valid_o, result_o, zero_o, illegal_o
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: decodes a request into ALU op/operands,
// lets the ALU evaluate for one cycle, then returns the captured result.
module alu_issue_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus
);

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  dec_legal;
  logic [3:0]            dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;

  // Request decode into ALU operation and operand selection.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    dec_a     = bus.rs1_data_i;
    dec_b     = bus.rs2_data_i;
    unique case (bus.opcode_i)
      OPC_RTYPE: begin
        if (bus.funct7_i == F7_BASE && bus.funct3_i == F3_ADD) begin
          dec_legal = 1'b1;
        end else if (bus.funct7_i == F7_BASE && bus.funct3_i == F3_OR) begin
          dec_legal = 1'b1;
          dec_op    = ALU_OR;
        end
      end
      OPC_ITYPE: begin
        dec_b = bus.imm_i;
        if (bus.funct3_i == F3_ADD) begin
          dec_legal = 1'b1;
        end else if (bus.funct3_i == F3_OR) begin
          dec_legal = 1'b1;
          dec_op    = ALU_OR;
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_a     = '0;
        dec_b     = bus.imm_i;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Issue FSM with registered ALU drive and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      bus.ALU_Operation_o <= ALU_ADD;
      bus.A_o             <= '0;
      bus.B_o             <= '0;
      bus.result_o        <= '0;
      bus.zero_o          <= 1'b0;
      bus.illegal_o       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.valid_i) begin
            if (dec_legal) begin
              bus.ALU_Operation_o <= dec_op;
              bus.A_o             <= dec_a;
              bus.B_o             <= dec_b;
              state               <= EXEC;
            end else begin
              // Illegal requests skip the ALU and answer immediately.
              bus.result_o  <= '0;
              bus.zero_o    <= 1'b0;
              bus.illegal_o <= 1'b1;
              state         <= RESP;
            end
          end
        end
        EXEC: begin
          bus.result_o  <= bus.ALU_Result_i;
          bus.zero_o    <= bus.Zero_i;
          bus.illegal_o <= 1'b0;
          state         <= RESP;
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o      = (state == IDLE) && !reset;
  assign bus.resp_valid_o = (state == RESP);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table for decode/result checks
// plus hand-written reset and backpressure sequences.
module tb_alu_issue_ctrl;

  localparam int unsigned DW = 32;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  alu_issue_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  alu_issue_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference ALU: op 0000 = ADD, op 0001 = OR.
  assign bus.ALU_Result_i = (bus.ALU_Operation_o == 4'b0001) ? (bus.A_o | bus.B_o)
                                                              : (bus.A_o + bus.B_o);
  assign bus.Zero_i = (bus.ALU_Result_i == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        ill;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    bus.opcode_i   = opc;
    bus.funct3_i   = f3;
    bus.funct7_i   = f7;
    bus.rs1_data_i = rs1;
    bus.rs2_data_i = rs2;
    bus.imm_i      = imm;
  endtask

  // Entered and left at a falling edge; request accepted at the rising edge between.
  task automatic issue(input vec_t v, output bit ok);
    int waited = 0;
    ok = 1'b1;
    while (!bus.ready_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL %s accept: ready_o never rose within %0d cycles", v.name, waited);
      ok = 1'b0;
      return;
    end
    drive(v.opc, v.f3, v.f7, v.rs1, v.rs2, v.imm);
    bus.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    drive(7'h7f, 3'h7, 7'h7f, 32'hBAD0_BAD0, 32'hBAD1_BAD1, 32'hBAD2_BAD2);
  endtask

  task automatic consume(input string name);
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    chk({name, " resp_valid after consume"}, 32'(bus.resp_valid_o), 32'd0);
    chk({name, " ready after consume"}, 32'(bus.ready_o), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    issue(v, ok);
    if (!ok) return;
    if (!v.ill) begin
      chk({v.name, " exec ready"}, 32'(bus.ready_o), 32'd0);
      chk({v.name, " exec resp_valid"}, 32'(bus.resp_valid_o), 32'd0);
      chk({v.name, " op"}, 32'(bus.ALU_Operation_o), 32'(v.op));
      chk({v.name, " A"}, bus.A_o, v.a);
      chk({v.name, " B"}, bus.B_o, v.b);
      @(negedge clk);
    end else begin
      chk({v.name, " op held"}, 32'(bus.ALU_Operation_o), 32'(v.op));
      chk({v.name, " A held"}, bus.A_o, v.a);
      chk({v.name, " B held"}, bus.B_o, v.b);
    end
    chk({v.name, " resp_valid"}, 32'(bus.resp_valid_o), 32'd1);
    chk({v.name, " result"}, bus.result_o, v.res);
    chk({v.name, " zero"}, 32'(bus.zero_o), 32'(v.z));
    chk({v.name, " illegal"}, 32'(bus.illegal_o), 32'(v.ill));
    consume(v.name);
  endtask

  vec_t vecs[10];
  vec_t tmp;
  bit   ok;

  initial begin
    n_vec = 0;
    n_err = 0;
    //        name       opc         f3      f7          rs1           rs2           imm           ill op     a             b             res           z
    vecs[0] = '{"add",   7'b0110011, 3'b000, 7'b0000000, 32'd7,        32'd5,        32'h0,        0, 4'h0, 32'd7,        32'd5,        32'd12,       0};
    vecs[1] = '{"addi0", 7'b0010011, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'h55,       32'd1,        0, 4'h0, 32'hFFFFFFFF, 32'd1,        32'd0,        1};
    vecs[2] = '{"ori",   7'b0010011, 3'b110, 7'b0100000, 32'h0F0,      32'h3,        32'h00F,      0, 4'h1, 32'h0F0,      32'h00F,      32'h0FF,      0};
    vecs[3] = '{"lui",   7'b0110111, 3'b101, 7'b1111111, 32'hDEAD,     32'h9,        32'h12345000, 0, 4'h0, 32'h0,        32'h12345000, 32'h12345000, 0};
    vecs[4] = '{"branch",7'b1100011, 3'b000, 7'b0000000, 32'h11,       32'h22,       32'h33,       1, 4'h0, 32'h0,        32'h12345000, 32'h0,        0};
    vecs[5] = '{"or",    7'b0110011, 3'b110, 7'b0000000, 32'hA0,       32'h0A,       32'h0,        0, 4'h1, 32'hA0,       32'h0A,       32'hAA,       0};
    vecs[6] = '{"sub",   7'b0110011, 3'b000, 7'b0100000, 32'h5,        32'h5,        32'h0,        1, 4'h1, 32'hA0,       32'h0A,       32'h0,        0};
    vecs[7] = '{"sll",   7'b0110011, 3'b001, 7'b0000000, 32'h5,        32'h1,        32'h0,        1, 4'h1, 32'hA0,       32'h0A,       32'h0,        0};
    vecs[8] = '{"add00", 7'b0110011, 3'b000, 7'b0000000, 32'h0,        32'h0,        32'h7,        0, 4'h0, 32'h0,        32'h0,        32'h0,        1};
    vecs[9] = '{"slti",  7'b0010011, 3'b010, 7'b0000000, 32'h1,        32'h2,        32'h3,        1, 4'h0, 32'h0,        32'h0,        32'h0,        0};

    reset = 1'b1;
    bus.valid_i = 1'b0;
    bus.resp_ready_i = 1'b0;
    drive(7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset ready", 32'(bus.ready_o), 32'd0);
    chk("reset resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("reset result", bus.result_o, 32'd0);
    chk("reset A", bus.A_o, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset ready", 32'(bus.ready_o), 32'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: response held 10 cycles while a new request waits.
    tmp = '{"bp", 7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'h0, 0, 4'h0, 32'd1, 32'd2, 32'd3, 0};
    issue(tmp, ok);
    @(negedge clk);
    drive(7'b0010011, 3'b110, 7'b0, 32'h100, 32'h0, 32'h001);
    bus.valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp ready", 32'(bus.ready_o), 32'd0);
      chk("bp resp_valid", 32'(bus.resp_valid_o), 32'd1);
      chk("bp result", bus.result_o, 32'd3);
      chk("bp A", bus.A_o, 32'd1);
      @(negedge clk);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    chk("bp released resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("bp released ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("bp next exec ready", 32'(bus.ready_o), 32'd0);
    chk("bp next A", bus.A_o, 32'h100);
    chk("bp next op", 32'(bus.ALU_Operation_o), 32'd1);
    @(negedge clk);
    chk("bp next resp_valid", 32'(bus.resp_valid_o), 32'd1);
    chk("bp next result", bus.result_o, 32'h101);
    consume("bp next");

    // Reset while a response holding 5 is pending.
    tmp = '{"rst", 7'b0010011, 3'b000, 7'b0, 32'd2, 32'd0, 32'd3, 0, 4'h0, 32'd2, 32'd3, 32'd5, 0};
    issue(tmp, ok);
    @(negedge clk);
    chk("rst pre result", bus.result_o, 32'd5);
    chk("rst pre resp_valid", 32'(bus.resp_valid_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst mid resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst mid result", bus.result_o, 32'd0);
    chk("rst mid ready", 32'(bus.ready_o), 32'd0);
    chk("rst mid A", bus.A_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst release ready", 32'(bus.ready_o), 32'd1);
    chk("rst release resp_valid", 32'(bus.resp_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
